// File: rtl/pc_gen_pkg.sv
// Shared CPU definitions for the fetch-PC generator: FSM state encoding and
// default reset vector / instruction step.
package pc_gen_pkg;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT = 2'd0;
    localparam pc_state_t ST_RUN  = 2'd1;
    localparam pc_state_t ST_PEND = 2'd2;

    localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
    localparam int unsigned INST_STEP_DEF = 4;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC / next-state selection for pc_gen.
// Priority: flush, branch, pending redirect, stall hold, sequential step.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INST_STEP = INST_STEP_DEF
) (
    input  pc_state_t         state_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pend_pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    output pc_state_t         state_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pend_pc_o
);

    always_comb begin
        state_o   = state_i;
        pc_o      = pc_i;
        pend_pc_o = pend_pc_i;
        if (state_i == ST_BOOT) begin
            // Redirects are ignored until the reset vector has been issued.
            state_o = ST_RUN;
        end else if (flush_i) begin
            pc_o      = flush_pc_i;
            pend_pc_o = '0;
            state_o   = ST_RUN;
        end else if (branch_i) begin
            if (stall_i) begin
                pend_pc_o = branch_pc_i;
                state_o   = ST_PEND;
            end else begin
                pc_o      = branch_pc_i;
                pend_pc_o = '0;
                state_o   = ST_RUN;
            end
        end else if (state_i == ST_PEND) begin
            if (!stall_i) begin
                pc_o      = pend_pc_i;
                pend_pc_o = '0;
                state_o   = ST_RUN;
            end
        end else if (!stall_i) begin
            pc_o = pc_i + ADDR_W'(INST_STEP);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: holds PC, fetch enable and a one-entry
// buffer for branch redirects that arrive while the fetch stage is stalled.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter int unsigned       INST_STEP = INST_STEP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              pend_o,
    output logic              adel_o
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              ce_q;

    pc_next_sel #(
        .ADDR_W    (ADDR_W),
        .INST_STEP (INST_STEP)
    ) u_next_sel (
        .state_i     (state_q),
        .pc_i        (pc_q),
        .pend_pc_i   (pend_pc_q),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .flush_pc_i  (flush_pc_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .state_o     (state_d),
        .pc_o        (pc_d),
        .pend_pc_o   (pend_pc_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VEC;
            pend_pc_q <= '0;
            ce_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            ce_q      <= (state_d != ST_BOOT);
        end
    end

    assign pc_o   = pc_q;
    assign ce_o   = ce_q;
    assign pend_o = (state_q == ST_PEND);
    assign adel_o = |pc_q[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch;
    logic [31:0] branch_pc;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        adel;

    int checks   = 0;
    int failures = 0;

    // Reference model: PC, a boot flag, and a queue holding at most one
    // buffered redirect target.
    logic [31:0] m_pc   = RV;
    bit          m_boot = 1'b1;
    logic [31:0] m_q[$];

    pc_gen u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .stall_i     (stall),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .branch_i    (branch),
        .branch_pc_i (branch_pc),
        .pc_o        (pc),
        .ce_o        (ce),
        .pend_o      (pend),
        .adel_o      (adel)
    );

    always #5 clk = ~clk;

    function automatic void model_edge();
        if (!rst_n) begin
            m_pc   = RV;
            m_boot = 1'b1;
            m_q.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (flush) begin
            m_pc = flush_pc;
            m_q.delete();
        end else if (branch && stall) begin
            m_q.delete();
            m_q.push_back(branch_pc);
        end else if (branch) begin
            m_pc = branch_pc;
            m_q.delete();
        end else if (m_q.size() != 0) begin
            if (!stall) begin
                m_pc = m_q.pop_front();
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    // Advance one edge; inputs were set away from the edge, outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst_n     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        branch    = 1'b0;
        branch_pc = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== RV || ce !== 1'b0 || pend !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h ce=%b pend=%b, want pc=%h ce=0 pend=0",
                     pc, ce, pend, RV);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (pc !== RV || ce !== 1'b1) begin
            failures++;
            $display("FAIL boot_exit: pc=%h ce=%b, want pc=%h ce=1", pc, ce, RV);
        end
        tick();
        checks++;
        if (pc !== 32'hBFC0_0004 || ce !== 1'b1) begin
            failures++;
            $display("FAIL seq_step1: pc=%h ce=%b, want pc=bfc00004 ce=1", pc, ce);
        end
        tick();
        checks++;
        if (pc !== 32'hBFC0_0008) begin
            failures++;
            $display("FAIL seq_step2: pc=%h, want bfc00008", pc);
        end
    endtask

    task automatic test_stalled_branch();
        logic [31:0] held;
        held      = pc;
        stall     = 1'b1;
        branch    = 1'b1;
        branch_pc = 32'h8000_1000;
        tick();
        branch = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== held || pend !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold_pend: pc=%h pend=%b, want pc=%h pend=1", pc, pend, held);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h8000_1000 || pend !== 1'b0) begin
            failures++;
            $display("FAIL pend_release: pc=%h pend=%b, want pc=80001000 pend=0", pc, pend);
        end
    endtask

    task automatic test_flush_pend();
        stall     = 1'b1;
        branch    = 1'b1;
        branch_pc = 32'h8000_2000;
        tick();
        branch = 1'b0;
        checks++;
        if (pend !== 1'b1) begin
            failures++;
            $display("FAIL pend_set: pend=%b, want 1", pend);
        end
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        checks++;
        if (pc !== 32'hBFC0_0380 || pend !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_pend: pc=%h pend=%b, want pc=bfc00380 pend=0", pc, pend);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'hBFC0_0384) begin
            failures++;
            $display("FAIL flush_discard: pc=%h, want bfc00384", pc);
        end
    endtask

    task automatic test_simultaneous();
        flush     = 1'b1;
        flush_pc  = 32'hBFC0_0380;
        branch    = 1'b1;
        branch_pc = 32'h8000_0000;
        tick();
        flush = 1'b0;
        checks++;
        if (pc !== 32'hBFC0_0380) begin
            failures++;
            $display("FAIL flush_vs_branch: pc=%h, want bfc00380", pc);
        end
        stall     = 1'b1;
        branch_pc = 32'h8000_0100;
        tick();
        stall     = 1'b0;
        branch_pc = 32'h8000_0200;
        tick();
        branch = 1'b0;
        checks++;
        if (pc !== 32'h8000_0200 || pend !== 1'b0) begin
            failures++;
            $display("FAIL new_branch_wins: pc=%h pend=%b, want pc=80000200 pend=0", pc, pend);
        end
        tick();
        checks++;
        if (pc !== 32'h8000_0204) begin
            failures++;
            $display("FAIL old_target_dropped: pc=%h, want 80000204", pc);
        end
    endtask

    task automatic test_wrap_misalign();
        branch    = 1'b1;
        branch_pc = 32'hFFFF_FFFC;
        tick();
        branch = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_0000 || adel !== 1'b0) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h adel=%b, want pc=00000000 adel=0", pc, adel);
        end
        branch    = 1'b1;
        branch_pc = 32'h8000_0002;
        tick();
        branch = 1'b0;
        checks++;
        if (pc !== 32'h8000_0002 || adel !== 1'b1) begin
            failures++;
            $display("FAIL misalign_load: pc=%h adel=%b, want pc=80000002 adel=1", pc, adel);
        end
        tick();
        checks++;
        if (pc !== 32'h8000_0006 || adel !== 1'b1) begin
            failures++;
            $display("FAIL misalign_step: pc=%h adel=%b, want pc=80000006 adel=1", pc, adel);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            stall     = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            branch    = ($urandom_range(0, 4) == 0);
            flush_pc  = $urandom();
            branch_pc = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                flush_pc[1:0]  = 2'b00;
                branch_pc[1:0] = 2'b00;
            end
            tick();
            checks++;
            if (pc !== m_pc || ce !== !m_boot || pend !== (m_q.size() != 0) ||
                adel !== (m_pc[1:0] != 2'b00)) begin
                failures++;
                bad++;
                if (bad <= 10) begin
                    $display("FAIL random_cycle %0d: pc=%h ce=%b pend=%b adel=%b, want pc=%h ce=%b pend=%b adel=%b",
                             i, pc, ce, pend, adel, m_pc, !m_boot, (m_q.size() != 0),
                             (m_pc[1:0] != 2'b00));
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stalled_branch();
        test_flush_pend();
        test_simultaneous();
        test_wrap_misalign();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'hBFC0_0000, PC value loaded at reset.
REQ-003 SHALL have parameter INST_STEP, default 4, sequential PC increment.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall_i  in  1  holds the PC; fetch stage cannot accept a new address.
REQ-007 SHALL have port flush_i  in  1  exception/eret redirect request.
REQ-008 SHALL have port flush_pc_i  in  ADDR_W  target for flush_i.
REQ-009 SHALL have port branch_i  in  1  resolved taken-branch/jump redirect request.
REQ-010 SHALL have port branch_pc_i  in  ADDR_W  target for branch_i.
REQ-011 SHALL have port pc_o  out  ADDR_W  current fetch PC, registered.
REQ-012 SHALL have port ce_o  out  1  fetch enable, registered.
REQ-013 SHALL have port pend_o  out  1  a branch redirect is buffered awaiting stall release.
REQ-014 SHALL have port adel_o  out  1  pc_o low two bits non-zero (fetch address error), combinational from pc_o.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, PEND.
REQ-016 SHALL, in BOOT, hold pc_o = RESET_VEC, ce_o = 0, and go to RUN on the next edge unconditionally (flush_i/branch_i ignored in BOOT).
REQ-017 SHALL set ce_o = 1 in RUN and PEND, and ce_o = 0 only in BOOT.
REQ-018 SHALL apply per-edge priority, highest first: flush_i, branch_i, pending redirect, stall_i hold, sequential increment.
REQ-019 SHALL, on flush_i = 1 in RUN or PEND, load pc_o <= flush_pc_i next edge regardless of stall_i, clear the pending buffer, and enter RUN.
REQ-020 SHALL, on branch_i = 1 with stall_i = 0 in RUN, load pc_o <= branch_pc_i next edge and stay in RUN.
REQ-021 SHALL, on branch_i = 1 with stall_i = 1, hold pc_o, capture branch_pc_i into the pending buffer, and enter or stay in PEND; a newer capture overwrites an older one.
REQ-022 SHALL, in PEND with stall_i = 0 and branch_i = 0, load pc_o <= pending target, clear the buffer, and enter RUN.
REQ-023 SHALL, in PEND with stall_i = 0 and branch_i = 1, load pc_o <= branch_pc_i, discard the buffer, and enter RUN.
REQ-024 SHALL, in PEND with stall_i = 1 and no event, hold pc_o and remain in PEND.
REQ-025 SHALL, in RUN with no event and stall_i = 0, load pc_o <= pc_o + INST_STEP, truncated to ADDR_W bits (wraps to 0 past all-ones).
REQ-026 SHALL, in RUN with stall_i = 1 and no event, hold pc_o.
REQ-027 SHALL assert pend_o exactly while in PEND.
REQ-028 SHALL load misaligned targets unchanged; adel_o flags them and no realignment is performed.
REQ-029 SHALL have one-cycle latency from any redirect input to pc_o.

Reset
REQ-030 SHALL, when rst_n_i = 0 at an edge, set pc_o = RESET_VEC, ce_o = 0, pending buffer = 0, and state = BOOT, overriding all other inputs.
REQ-031 SHALL discard any pending redirect when reset is applied mid-operation.

Structure
REQ-032 SHALL declare the FSM state enum and the default RESET_VEC/INST_STEP constants in the shared CPU package.
REQ-033 SHALL place next-PC selection in one combinational sub-module, pc_next_sel; state, PC and buffer registers stay in pc_gen.

Verification
REQ-034 Reset: rst_n_i = 0 for 2 cycles, then released -> pc_o = BFC0_0000 with ce_o = 0 for one cycle, then ce_o = 1 and pc_o = BFC0_0004, BFC0_0008.
REQ-035 Stalled branch: stall_i = 1 for 3 cycles with branch_i pulse of target 8000_1000 in cycle 1 -> pc_o held, pend_o = 1; one cycle after stall release pc_o = 8000_1000 and pend_o = 0.
REQ-036 Flush vs stalled pending: pend_o = 1, then flush_i with flush_pc_i = BFC0_0380 while stall_i = 1 -> next pc_o = BFC0_0380, pend_o = 0.
REQ-037 Simultaneous events: flush_i (BFC0_0380) and branch_i (8000_0000) in the same cycle -> pc_o = BFC0_0380; branch_i on the stall-release cycle in PEND -> new target wins.
REQ-038 Wrap and misalignment: pc_o = FFFF_FFFC, no stall -> pc_o = 0000_0000; branch to 8000_0002 -> adel_o = 1.
